// File: rtl/enc_pkg.sv
// Shared encoder constants, packer phase enum and symbol type.
package enc_pkg;

    localparam int EGF_ORDER   = 8;
    localparam int ENC_SYM_NUM = 16;
    localparam int RS_COD_LEN  = 255;

    // First beat of a codeword carries the leftover symbols, the rest are full beats.
    localparam int ENC_HALF = RS_COD_LEN % ENC_SYM_NUM;
    localparam int ENC_FULL = RS_COD_LEN / ENC_SYM_NUM;

    typedef enum logic {
        PK_HDR  = 1'b0,
        PK_BODY = 1'b1
    } PK_PHASE;

    typedef logic [EGF_ORDER-1:0] enc_sym_t;

endpackage

// File: rtl/enc_packer_shift.sv
// Combinational merge of the held residue with one input beat; both are kept
// left-aligned (earliest symbol in the top lane) so the merge is a single shift.
module enc_packer_shift #(
    parameter int SYM_W   = 8,
    parameter int SYM_NUM = 16,
    parameter int HALF    = 15,
    localparam int BW     = SYM_NUM * SYM_W,
    localparam int RW     = $clog2(SYM_NUM)
) (
    input  logic [BW-1:0] res_data,
    input  logic [RW-1:0] res_cnt,
    input  logic [BW-1:0] in_data,
    input  logic          in_half,
    output logic          emit,
    output logic [BW-1:0] emit_data,
    output logic [BW-1:0] res_data_nxt,
    output logic [RW-1:0] res_cnt_nxt
);

    logic [BW-1:0]   in_al;
    logic [RW:0]     in_cnt;
    logic [RW:0]     sym_total;
    logic [2*BW-1:0] merged;

    always_comb begin
        // Half-beat symbols sit in the low lanes; lift them to the top so garbage lanes fall off.
        in_al     = in_half ? (in_data << ((SYM_NUM - HALF) * SYM_W)) : in_data;
        in_cnt    = in_half ? (RW+1)'(HALF) : (RW+1)'(SYM_NUM);
        sym_total = {1'b0, res_cnt} + in_cnt;
        merged    = {res_data, {BW{1'b0}}}
                  | ({{BW{1'b0}}, in_al} << ((SYM_NUM - int'(res_cnt)) * SYM_W));
        emit      = (sym_total >= (RW+1)'(SYM_NUM));
        emit_data = merged[2*BW-1:BW];
        if (emit) begin
            res_data_nxt = merged[BW-1:0];
            res_cnt_nxt  = RW'(sym_total - (RW+1)'(SYM_NUM));
        end else begin
            res_data_nxt = merged[2*BW-1:BW];
            res_cnt_nxt  = RW'(sym_total);
        end
    end

endmodule

// File: rtl/enc_packer.sv
// Packs codeword-aligned beats (one half beat, then full beats) into a gapless symbol stream.
// Optional residue flush and out_cnt are enabled by defining ENC_PACKER_FLUSH_EN.
module enc_packer
    import enc_pkg::*;
#(
    parameter int EGF_W   = EGF_ORDER,
    parameter int SYM_NUM = ENC_SYM_NUM,
    parameter int COD_LEN = RS_COD_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_half,
    input  logic [SYM_NUM*EGF_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SYM_NUM*EGF_W-1:0] out_data,
    output logic                     out_err
`ifdef ENC_PACKER_FLUSH_EN
    ,
    input  logic                          in_flush,
    output logic [$clog2(SYM_NUM+1)-1:0]  out_cnt
`endif
);

    localparam int HALF = COD_LEN % SYM_NUM;
    localparam int FULL = COD_LEN / SYM_NUM;
    localparam int BW   = SYM_NUM * EGF_W;
    localparam int RW   = $clog2(SYM_NUM);
    localparam int CW   = (FULL > 1) ? $clog2(FULL) : 1;

    PK_PHASE       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] res_q, res_d;
    logic [RW-1:0] res_cnt_q, res_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [BW-1:0] out_data_q, out_data_d;
    logic          err_q, err_d;

    logic          accept;
    logic          violation;
    logic          flush_go;
    logic          sh_emit;
    logic [BW-1:0] sh_data;
    logic [BW-1:0] sh_res;
    logic [RW-1:0] sh_res_cnt;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = err_q;

    enc_packer_shift #(
        .SYM_W   (EGF_W),
        .SYM_NUM (SYM_NUM),
        .HALF    (HALF)
    ) u_shift (
        .res_data     (res_q),
        .res_cnt      (res_cnt_q),
        .in_data      (in_data),
        .in_half      (in_half),
        .emit         (sh_emit),
        .emit_data    (sh_data),
        .res_data_nxt (sh_res),
        .res_cnt_nxt  (sh_res_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PK_HDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A half beat always resyncs to the body; a stray full beat in PK_HDR leaves us waiting for a header.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            if (in_half) begin
                state_d = PK_BODY;
                cnt_d   = '0;
            end else if (state_q == PK_BODY) begin
                if (cnt_q == CW'(FULL - 1)) begin
                    state_d = PK_HDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_comb begin
        violation = accept && (in_half != (state_q == PK_HDR));
    end

`ifdef ENC_PACKER_FLUSH_EN
    localparam int OCW = $clog2(SYM_NUM + 1);

    logic           flush_pend_q, flush_pend_d;
    logic           flush_req;
    logic [OCW-1:0] out_cnt_q, out_cnt_d;

    assign out_cnt = out_cnt_q;

    // A flush arriving with a beat is deferred one cycle so the beat lands first.
    always_comb begin
        flush_req = in_flush || flush_pend_q;
        flush_go  = flush_req && !accept && in_ready
                    && (res_cnt_q != '0) && (state_q == PK_HDR);
        if (accept) begin
            flush_pend_d = flush_req;
        end else if (in_ready) begin
            flush_pend_d = 1'b0;
        end else begin
            flush_pend_d = flush_pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend_q <= 1'b0;
            out_cnt_q    <= '0;
        end else begin
            flush_pend_q <= flush_pend_d;
            out_cnt_q    <= out_cnt_d;
        end
    end
`else
    assign flush_go = 1'b0;
`endif

    always_comb begin
        res_d       = res_q;
        res_cnt_d   = res_cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        err_d       = err_q || violation;
`ifdef ENC_PACKER_FLUSH_EN
        out_cnt_d   = out_cnt_q;
`endif
        if (accept) begin
            res_d     = sh_res;
            res_cnt_d = sh_res_cnt;
            if (sh_emit) begin
                out_valid_d = 1'b1;
                out_data_d  = sh_data;
`ifdef ENC_PACKER_FLUSH_EN
                out_cnt_d   = OCW'(SYM_NUM);
`endif
            end
        end else if (flush_go) begin
            out_valid_d = 1'b1;
            out_data_d  = res_q;
            res_d       = '0;
            res_cnt_d   = '0;
`ifdef ENC_PACKER_FLUSH_EN
            out_cnt_d   = OCW'(res_cnt_q);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q       <= '0;
            res_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

endmodule
